// File: rtl/alu_result_stage.sv
// alu_result_stage: classifies ALU results, queues them in a 2-entry FIFO for writeback
// and keeps sticky overflow / illegal-function exception state.
module alu_result_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  func,
    input  logic [31:0] alu_o,
    input  logic        alu_ov,
    input  logic [4:0]  dest,
    input  logic        trap_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_dest,
    output logic        out_we,
    output logic        out_br,
    output logic        exc_ov,
    output logic        exc_illegal,
    input  logic        exc_clear,
    output logic [7:0]  exc_count
);
    logic [31:0] mem_data [2];
    logic [4:0]  mem_dest [2];
    logic [1:0]  mem_we;
    logic [1:0]  mem_br;
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        is_arith;
    logic        is_logic;
    logic        is_branch;
    logic        is_illegal;
    logic        trap;
    logic        we_in;
    logic        push;
    logic        pop;

    always_comb begin
        is_arith   = func == 6'b000010 || func == 6'b000100;
        is_logic   = func inside {6'b001000, 6'b010000, 6'b100000, 6'b000011,
                                  6'b000101, 6'b001001, 6'b010001};
        is_branch  = func == 6'b100001 || func == 6'b100011;
        is_illegal = !(is_arith || is_logic || is_branch);
        trap       = is_arith && trap_en && alu_ov;
        we_in      = !(trap || is_branch || is_illegal || dest == 5'd0);
    end

    // in_ready depends only on the occupancy register, never on out_ready
    assign in_ready  = !count[1];
    assign out_valid = |count;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_data[rd_ptr];
    assign out_dest  = mem_dest[rd_ptr];
    assign out_we    = mem_we[rd_ptr];
    assign out_br    = mem_br[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data    <= '{default: '0};
            mem_dest    <= '{default: '0};
            mem_we      <= '0;
            mem_br      <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= '0;
            exc_ov      <= 1'b0;
            exc_illegal <= 1'b0;
            exc_count   <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= alu_o;
                mem_dest[wr_ptr] <= dest;
                mem_we[wr_ptr]   <= we_in;
                mem_br[wr_ptr]   <= is_branch && alu_ov;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count       <= count + {1'b0, push} - {1'b0, pop};
            // a new exception beats a simultaneous clear
            exc_ov      <= (push && trap) || (exc_ov && !exc_clear);
            exc_illegal <= (push && is_illegal) || (exc_illegal && !exc_clear);
            if (push && trap && exc_count != 8'hff)
                exc_count <= exc_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench; stimulus pushes expected entries, a monitor
// pops and compares them whenever the DUT hands an entry to writeback.
module tb_alu_result_stage;
    typedef struct {
        logic [31:0] data;
        logic [4:0]  dest;
        logic        we;
        logic        br;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  func = '0;
    logic [31:0] alu_o = '0;
    logic        alu_ov = 1'b0;
    logic [4:0]  dest = '0;
    logic        trap_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_dest;
    logic        out_we;
    logic        out_br;
    logic        exc_ov;
    logic        exc_illegal;
    logic        exc_clear = 1'b0;
    logic [7:0]  exc_count;

    ent_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   occ = 0;
    bit   m_ov = 0;
    bit   m_ill = 0;
    int   m_cnt = 0;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .func(func), .alu_o(alu_o), .alu_ov(alu_ov), .dest(dest), .trap_en(trap_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_dest(out_dest), .out_we(out_we), .out_br(out_br), .exc_ov(exc_ov),
        .exc_illegal(exc_illegal), .exc_clear(exc_clear), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = arith, 1 = logic/compare, 2 = branch, 3 = illegal
    function automatic int fclass(input logic [5:0] f);
        if (f inside {6'd2, 6'd4}) return 0;
        if (f inside {6'd8, 6'd16, 6'd32, 6'd3, 6'd5, 6'd9, 6'd17}) return 1;
        if (f inside {6'd33, 6'd35}) return 2;
        return 3;
    endfunction

    // one clock of stimulus: check model state, predict the edge, advance
    task automatic step();
        bit   push, pop, trap;
        int   c;
        ent_t e;
        @(negedge clk);
        chk("in_ready", in_ready, occ < 2);
        chk("out_valid", out_valid, occ > 0);
        chk("exc_ov", exc_ov, m_ov);
        chk("exc_illegal", exc_illegal, m_ill);
        chk("exc_count", exc_count, m_cnt);
        push = in_valid && occ < 2;
        pop  = occ > 0 && out_ready;
        c    = fclass(func);
        trap = push && c == 0 && trap_en && alu_ov;
        if (push) begin
            e.data = alu_o;
            e.dest = dest;
            e.br   = c == 2 && alu_ov;
            e.we   = !((c == 0 && trap_en && alu_ov) || c >= 2 || dest == 0);
            sb.push_back(e);
        end
        m_ov  = trap || (m_ov && !exc_clear);
        m_ill = (push && c == 3) || (m_ill && !exc_clear);
        if (trap && m_cnt < 255) m_cnt++;
        occ = occ + int'(push) - int'(pop);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] o,
                         input logic ov, input logic [4:0] d, input logic te,
                         input logic ordy, input logic clr);
        in_valid = v; func = f; alu_o = o; alu_ov = ov; dest = d; trap_en = te;
        out_ready = ordy; exc_clear = clr;
        step();
    endtask

    task automatic idle(input logic ordy, input int n);
        for (int i = 0; i < n; i++) drive(0, 6'd0, 32'd0, 0, 5'd0, 0, ordy, 0);
    endtask

    // monitor: the head leaves on the coming edge whenever out_valid && out_ready
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_dest", out_dest, e.dest);
                    chk("out_we", out_we, e.we);
                    chk("out_br", out_br, e.br);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] codes [13];
        codes = '{6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd3, 6'd5, 6'd9, 6'd17,
                  6'd33, 6'd35, 6'd63, 6'd0};
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_dest", out_dest, 0);
        chk("rst_out_we", out_we, 0);
        chk("rst_out_br", out_br, 0);
        chk("rst_exc_count", exc_count, 0);
        chk("rst_exc_flags", {exc_ov, exc_illegal}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic add, then sub overflow trapped / untrapped
        drive(1, 6'd2, 32'h5, 0, 5'd3, 1, 1, 0);
        drive(1, 6'd4, 32'h77, 1, 5'd4, 1, 1, 0);
        drive(1, 6'd4, 32'h78, 1, 5'd4, 0, 1, 0);
        idle(1, 2);
        // full FIFO: third push refused, then drain in order
        drive(1, 6'd8, 32'hA, 0, 5'd1, 0, 0, 0);
        drive(1, 6'd8, 32'hB, 0, 5'd1, 0, 0, 0);
        drive(1, 6'd8, 32'hC, 0, 5'd1, 0, 0, 0);
        idle(1, 3);
        // taken bne to r0, illegal code, clear
        drive(1, 6'd35, 32'h1234, 1, 5'd0, 0, 1, 0);
        drive(1, 6'd63, 32'hdead, 0, 5'd7, 0, 1, 0);
        idle(1, 1);
        drive(0, 6'd0, 32'd0, 0, 5'd0, 0, 1, 1);
        // push and pop together at occupancy 1; set beats clear
        drive(1, 6'd16, 32'h100, 0, 5'd9, 0, 0, 0);
        drive(1, 6'd2, 32'h200, 1, 5'd10, 1, 1, 1);
        idle(0, 1);
        idle(1, 2);
        // saturate the trap counter
        for (int i = 0; i < 260; i++) drive(1, 6'd2, i, 1, 5'(i), 1, 1, 0);
        idle(1, 2);
        // fill both entries then reset asynchronously
        drive(1, 6'd8, 32'h11, 0, 5'd2, 0, 0, 0);
        drive(1, 6'd8, 32'h22, 0, 5'd2, 0, 0, 0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_exc_count", exc_count, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_exc_ov", exc_ov, 0);
        sb.delete();
        occ = 0; m_ov = 0; m_ill = 0; m_cnt = 0;
        #1 rst_n = 1'b1;
        drive(1, 6'd9, 32'h33, 0, 5'd5, 0, 1, 0);
        idle(1, 2);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [5:0] f;
            f = $urandom_range(0, 15) < 13 ? codes[$urandom_range(0, 12)] : 6'($urandom);
            drive(1'($urandom_range(0, 3) != 0), f, $urandom, 1'($urandom),
                  5'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0));
        end
        idle(1, 3);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  ALU result presented this cycle.
REQ-005 in_ready  output  1  stage can accept a result this cycle.
REQ-006 func  input  6  ALU function code that produced the result.
REQ-007 alu_o  input  32  ALU result O.
REQ-008 alu_ov  input  1  ALU flag OV: overflow for add/sub, branch condition for compare codes.
REQ-009 dest  input  5  destination register index.
REQ-010 trap_en  input  1  overflow traps this operation (add/sub vs addu/subu).
REQ-011 out_valid  output  1  head entry valid.
REQ-012 out_ready  input  1  writeback consumes head entry.
REQ-013 out_data  output  32  head result.
REQ-014 out_dest  output  5  head destination.
REQ-015 out_we  output  1  head entry writes the register file.
REQ-016 out_br  output  1  head entry is a taken branch.
REQ-017 exc_ov  output  1  sticky overflow-exception flag.
REQ-018 exc_illegal  output  1  sticky unknown-func flag.
REQ-019 exc_clear  input  1  clears both sticky flags.
REQ-020 exc_count  output  8  count of trapped overflows, saturating.

Function
REQ-021 Func classes SHALL be: ARITH = 000010 (add), 000100 (sub); LOGIC/CMP = 001000, 010000, 100000, 000011, 000101, 001001, 010001; BRANCH = 100001 (beq), 100011 (bne); every other code is ILLEGAL.
REQ-022 Storage SHALL be a 2-entry FIFO holding {data, dest, we, br}; occupancy is 0..2.
REQ-023 in_ready SHALL be 1 exactly when occupancy < 2, registered, with no combinational path from out_ready.
REQ-024 A push SHALL occur on a rising edge with in_valid && in_ready; a pop on a rising edge with out_valid && out_ready; a push and a pop in the same edge leave occupancy unchanged.
REQ-025 Latency SHALL be 1 cycle: a push into an empty FIFO gives out_valid=1 with that entry on the next cycle.
REQ-026 out_valid SHALL be 1 exactly when occupancy > 0; out_* SHALL show the oldest entry, and entries leave in push order.
REQ-027 we SHALL equal 0 when any of these holds, and 1 otherwise:
  - ARITH && trap_en && alu_ov
  - BRANCH
  - ILLEGAL
  - dest == 0
REQ-028 br SHALL equal alu_ov for BRANCH and 0 otherwise; data SHALL equal alu_o unchanged in all cases.
REQ-029 A push with ARITH && trap_en && alu_ov SHALL set exc_ov and increment exc_count, which holds at 255.
REQ-030 A push with ILLEGAL SHALL set exc_illegal.
REQ-031 exc_clear SHALL clear exc_ov and exc_illegal; when a set and exc_clear occur on the same edge, the set wins; exc_count is never cleared except by reset.
REQ-032 in_valid while in_ready=0 SHALL be ignored: no push, no flag update.
REQ-033 The pointers SHALL be 1 bit each and wrap modulo 2.

Reset
REQ-034 While rst_n=0, all of the following SHALL hold immediately, without waiting for a clock edge:
  - occupancy 0, out_valid=0, in_ready=1
  - out_data=0, out_dest=0, out_we=0, out_br=0
  - exc_ov=0, exc_illegal=0, exc_count=0
REQ-035 Reset asserted mid-operation SHALL discard all FIFO entries; the first push after rst_n rises is accepted on the first rising edge.

Verification
REQ-036 Push func=000010, alu_o=0x00000005, dest=3, alu_ov=0, trap_en=1, out_ready=1 -> next cycle out_valid=1, out_data=0x5, out_dest=3, out_we=1, out_br=0.
REQ-037 Push func=000100, alu_ov=1, trap_en=1 -> out_we=0, exc_ov=1, exc_count=1; same push with trap_en=0 -> out_we=1, exc_count unchanged.
REQ-038 out_ready=0, three back-to-back pushes with data 0xA, 0xB, 0xC -> in_ready=0 after the second push, 0xC not accepted; then out_ready=1 -> outputs 0xA, then 0xB, then in_ready=1.
REQ-039 Push func=100011, alu_ov=1, dest=0 -> out_br=1, out_we=0; push func=111111 -> exc_illegal=1, out_we=0.
REQ-040 Occupancy 1 with push and pop on the same edge -> occupancy stays 1, new entry at the head next cycle; exc_clear on the same edge as an overflow set -> exc_ov=1.
REQ-041 Trap 256 overflows -> exc_count=255; assert rst_n=0 with 2 entries held -> out_valid=0 and exc_count=0 without a clock edge.
